logic_gate_pipe: RTL and testbench

- Parametrised successor to the single-bit 2-input OR gate: WIDTH-bit bitwise logic unit, 8 runtime-selectable operations.
- Two-stage registered pipeline with valid/ready handshakes on input and output, plus a wrapping completed-transaction counter.
- Sits between a stimulus/operand source and a result consumer; the datapath gate primitive for wider designs.

---
 rtl/logic_gate_pipe.sv | 127 ++++++++++++
 tb/tb_logic_gate_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - two-stage registered WIDTH-bit bitwise logic unit with valid/ready handshakes
// Optional feature macro: LOGIC_GATE_PIPE_PARITY_EN adds the y_par output.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] txn_count
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  ,
  output logic             y_par
`endif
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  // Stage 1 holds the captured operand beat
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;

  // Stage 2 holds the result; y itself is the stage-2 data register
  logic             s2_valid;
  logic             s1_ready;
  logic             s2_ready;
  logic [WIDTH-1:0] s1_result;

  // Bitwise operation selected by the captured op code
  function automatic logic [WIDTH-1:0] gate_eval(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] f_a,
    input logic [WIDTH-1:0] f_b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (f_op)
      OP_AND:  r = f_a & f_b;
      OP_OR:   r = f_a | f_b;
      OP_XOR:  r = f_a ^ f_b;
      OP_NAND: r = ~(f_a & f_b);
      OP_NOR:  r = ~(f_a | f_b);
      OP_XNOR: r = ~(f_a ^ f_b);
      OP_PASS: r = f_a;
      OP_NOTA: r = ~f_a;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign s1_result = gate_eval(s1_op, s1_a, s1_b);

  // A stage may take new data when it is empty or when its occupant leaves this cycle;
  // this lets a bubble in S2 collapse even while the consumer stalls
  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  // During reset both stages are being cleared, so the unit reports ready
  assign in_ready  = s1_ready || !rst_n;
  assign out_valid = s2_valid;

  // Stage 1: capture an operand beat on an input handshake, empty when it moves on with nothing behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op;
      end
    end
  end

  // Stage 2: register the computed result; holds stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y <= s1_result;
      end
    end
  end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
  // Parity of the result, registered alongside y so it shares its timing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (s2_ready && s1_valid) begin
      y_par <= ^s1_result;
    end
  end
`endif

  // Count completed output handshakes, wrapping naturally at the counter width
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (s2_valid && out_ready) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - scoreboard bench for logic_gate_pipe with randomized handshakes
module tb_logic_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;

  wire        in_ready;
  wire        out_valid;
  wire [7:0]  y;
  wire [15:0] txn_count;
  wire        in_ready4;
  wire        out_valid4;
  wire [7:0]  y4;
  wire [3:0]  txn4;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  wire        y_par;
  wire        y_par4;
`endif

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .txn_count(txn_count)
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    , .y_par(y_par)
`endif
  );

  // Narrow-counter instance fed identically, used to observe counter wrap
  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .txn_count(txn4)
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    , .y_par(y_par4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } beat_t;

  typedef struct {
    logic [7:0] exp;
    int         acc;
  } exp_t;

  beat_t stim[$];
  exp_t  expq[$];

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int hs = 0;
  int accepted = 0;
  bit mon_en = 1'b0;
  bit chk_lat = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_y = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}
  function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
    logic [3:0] tt [8];
    logic [3:0] row;
    logic [7:0] r;
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b0011};
    row = tt[mop];
    for (int i = 0; i < 8; i++) r[i] = row[{ma[i], mb[i]}];
    return r;
  endfunction

  task automatic push_beat(input logic [7:0] pa, input logic [7:0] pb, input logic [2:0] pop, input logic [7:0] pexp);
    beat_t t;
    t.a = pa; t.b = pb; t.op = pop; t.exp = pexp;
    stim.push_back(t);
  endtask

  // One clock of stimulus: drive at the falling edge, record the accept just after
  task automatic cycle(input bit iv_en, input bit ordy);
    exp_t e;
    @(negedge clk);
    cyc++;
    out_ready = ordy;
    if (iv_en && stim.size() > 0) begin
      in_valid = 1'b1;
      a = stim[0].a; b = stim[0].b; op = stim[0].op;
    end else begin
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    end
    #1;
    if (in_valid && in_ready) begin
      e.exp = stim[0].exp;
      e.acc = cyc;
      expq.push_back(e);
      void'(stim.pop_front());
      accepted++;
    end
  endtask

  task automatic run(input int limit, input int iv_pct, input int or_pct);
    int n = 0;
    while ((stim.size() > 0 || expq.size() > 0) && n < limit) begin
      cycle($urandom_range(99, 0) < iv_pct, $urandom_range(99, 0) < or_pct);
      n++;
    end
    if (n >= limit) chk("run_timeout_pending", 64'(expq.size() + stim.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    @(negedge clk);
    cyc++;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_txn_count_w4", txn4, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    cyc++;
    expq.delete();
    stim.delete();
    hs = 0;
    prev_hold = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst_n) begin
        chk("txn_count", txn_count, 64'(hs % 65536));
        chk("txn_count_w4", txn4, 64'(hs % 16));
        if (prev_hold) begin
          chk("stall_out_valid", out_valid, 1);
          chk("stall_y", y, prev_y);
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
          end else begin
            e = expq.pop_front();
            chk("y", y, e.exp);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
            chk("y_par", y_par, ^e.exp);
`endif
            if (chk_lat) chk("latency", 64'(cyc - e.acc), 2);
          end
          hs++;
        end
        prev_hold = out_valid && !out_ready;
        prev_y = y;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d beats pending", expq.size());
    $fatal(1);
  end

  initial begin
    logic [7:0] tt_exp [8];
    int acc0;
    tt_exp = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'hC3, 8'h3C};

    // Reset with in_valid held high; nothing may come out afterwards
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    chk("post_reset_out_valid", out_valid, 0);

    // Truth table back-to-back with no stall
    for (int i = 0; i < 8; i++) push_beat(8'hC3, 8'hA5, 3'(i), tt_exp[i]);
    chk_lat = 1'b1;
    run(40, 100, 100);
    chk_lat = 1'b0;
    cycle(1'b0, 1'b1);
    chk("tt_txn_count", txn_count, 8);

    // Backpressure: only two beats fit while the consumer stalls
    push_beat(8'h7F, 8'h00, 3'd1, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] rop;
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      push_beat(ra, rb, rop, model(ra, rb, rop));
    end
    acc0 = accepted;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    chk("bp_accepted", 64'(accepted - acc0), 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_y_head", y, 8'h7F);
    run(40, 100, 100);
    chk("bp_all_accepted", 64'(accepted - acc0), 4);

    // Random valid/ready over 1000 beats
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] rop;
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      push_beat(ra, rb, rop, model(ra, rb, rop));
    end
    run(20000, 70, 65);
    cycle(1'b0, 1'b1);
    chk("rand_txn_count", txn_count, 64'(hs % 65536));
    chk("rand_scoreboard_empty", 64'(expq.size()), 0);

    // Reset while both stages hold beats: they must be discarded
    push_beat(8'h12, 8'h34, 3'd2, model(8'h12, 8'h34, 3'd2));
    push_beat(8'h56, 8'h78, 3'd0, model(8'h56, 8'h78, 3'd0));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    chk("mid_full_in_ready", in_ready, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    chk("mid_reset_out_valid", out_valid, 0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] rop;
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      push_beat(ra, rb, rop, model(ra, rb, rop));
    end
    run(200, 80, 80);
    cycle(1'b0, 1'b1);
    chk("wrap_txn_count_w4", txn4, 1);
    chk("wrap_txn_count", txn_count, 17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
